sbox_prog_table: RTL and testbench
==================================

Name: sbox_prog_table

Overview:
- Parametrised, run-time-programmable DES S-box table.
- Generalises the fixed 6-in/4-out editable S-box to IN_W inputs and OUT_W outputs, with any of the eight DES tables selectable as the reset default.
- Adds a valid/ready lookup pipeline, a handshaked write port, a registered read-back port and a multi-cycle restore-defaults sequencer that runs without reset.
- Sits in the round function between the key-mixing XOR and the P-permutation. Eight instances, SBOX_ID 0..7, share one programming bus.

Parameters:
- SBOX_ID, 0: table identity (0..7); selects default contents and matches wr_sel/rd_sel.
- IN_W, 6: lookup input width, minimum 3. Row = {i_data[IN_W-1], i_data[0]}. Column = i_data[IN_W-2:1].
- OUT_W, 4: entry width.
- LOOKUP_REG, 1: 1 = registered lookup output (latency 1); 0 = combinational (latency 0).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  lookup request
- i_ready  out  1  lookup accepted when i_valid && i_ready
- i_data  in  IN_W  lookup index
- o_valid  out  1  lookup result valid
- o_data  out  OUT_W  lookup result
- wr_valid  in  1  write request
- wr_ready  out  1  write port free
- wr_sel  in  3  target S-box id
- wr_row  in  2  target row
- wr_col  in  IN_W-2  target column
- wr_data  in  OUT_W  new entry value
- rd_req  in  1  read-back request (single-cycle pulse)
- rd_sel  in  3  read-back S-box id
- rd_row  in  2  read-back row
- rd_col  in  IN_W-2  read-back column
- rd_valid  out  1  read-back data valid
- rd_data  out  OUT_W  read-back value
- restore_req  in  1  start restore-defaults (pulse)
- busy  out  1  restore in progress
- restore_done  out  1  one-cycle pulse at restore completion

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Storage: 4 x 2^(IN_W-2) entries of OUT_W bits (DEPTH = 2^IN_W).
- Reset contents:
  - IN_W=6 and OUT_W=4: the standard DES S-box SBOX_ID+1.
  - Any other geometry: all zero.
- Reset values: o_valid=0, o_data=0, rd_valid=0, rd_data=0, busy=0, restore_done=0, FSM=IDLE, restore pointer=0.
- FSM states:
  - IDLE: i_ready=1, wr_ready=1.
  - IDLE -> RESTORE on restore_req.
  - RESTORE: busy=1, i_ready=0, wr_ready=0. One entry per cycle is rewritten with its default, pointer 0..DEPTH-1. After the write of entry DEPTH-1 the FSM returns to IDLE and restore_done pulses in that same cycle. Total DEPTH cycles.
  - restore_req during RESTORE: ignored; no restart.
- Lookup:
  - LOOKUP_REG=1: o_valid and o_data register the accepted lookup at the next edge. With no accepted lookup, o_valid=0 and o_data holds its previous value.
  - LOOKUP_REG=0: o_valid = i_valid && i_ready; o_data is combinational.
- Write:
  - Committed at the edge when wr_valid && wr_ready && wr_sel==SBOX_ID.
  - wr_sel != SBOX_ID: no effect. wr_ready stays 1 so the shared bus does not stall.
- Write/lookup collision on the same entry in the same cycle: the lookup returns the old value; the new value is visible from the next cycle.
- Read-back:
  - rd_req && rd_sel==SBOX_ID -> rd_valid=1 and rd_data=entry at the next edge. Otherwise rd_valid=0 and rd_data holds.
  - Allowed during RESTORE; returns current (possibly already restored) contents.
  - Same-cycle write collision: returns the old value.
- Reset mid-restore: the table returns immediately to defaults and the FSM to IDLE; no restore_done pulse.
- Width rule: wr_data and table entries are exactly OUT_W bits; no truncation or extension.

Decomposition:
- Package des_sbox_pkg:
  - the 8x64 DES default table as a constant;
  - function sbox_default(id, row, col) returning 4 bits;
  - localparams for row-bit count (2) and S-box id width (3).
- Sub-module sbox_restore_fsm: IDLE/RESTORE state, pointer counter, busy and restore_done. The parent owns storage, lookup and the read-back path.

Test Plan:
- Reset, SBOX_ID=6, LOOKUP_REG=1; lookup i_data=6'b000000, then 6'b100001 -> o_data=4, then 6, each one cycle later with o_valid=1.
- Write wr_sel=6, row 1, col 2, data 4'hF; next cycle lookup 6'b000101 -> 4'hF. The same write with wr_sel=3 leaves the entry at 11.
- Write row 0, col 0 = 4'h9 in the same cycle as lookup 6'b000000 -> o_data=4. Lookup on the following cycle -> 9.
- Edit 5 entries, pulse restore_req:
  - busy=1 for exactly 64 cycles;
  - i_ready=0 and wr_ready=0 throughout;
  - restore_done pulses once;
  - rd_req row 1, col 2 afterwards -> rd_data=11.
- Assert rst_n=0 at restore cycle 20 -> busy=0 immediately, all entries default, no restore_done pulse.
- LOOKUP_REG=0, IN_W=6: sweep all 64 inputs -> o_data matches des_sbox_pkg table 6 in the same cycle.

Source files
------------

// File: rtl/des_sbox_pkg.sv
// des_sbox_pkg
// Shared definitions for the programmable DES S-box tables: the eight
// standard DES S-boxes as constants, a lookup helper returning the default
// entry of any table, the restore sequencer state encoding and the widths
// of the row and S-box id fields on the programming bus.
// No ports (package).

package des_sbox_pkg;

    localparam int ROW_BITS  = 2;
    localparam int ID_W      = 3;
    localparam int DES_IN_W  = 6;
    localparam int DES_OUT_W = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RESTORE = 1'b1
    } restore_state_t;

    // Each table is 64 nibbles, row-major (row 0 col 0 first), with the
    // first entry in the most significant nibble so the hex reads like the
    // printed DES tables.
    localparam logic [255:0] DES_SBOX [0:7] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // Default entry of DES table 'id' (0 = S1) at the given row/column.
    function automatic logic [DES_OUT_W-1:0] sbox_default(
        input logic [ID_W-1:0]     id,
        input logic [ROW_BITS-1:0] row,
        input logic [3:0]          col
    );
        int unsigned pos;
        pos = (32'd63 - 32'({row, col})) * 32'd4;
        return DES_SBOX[id][pos +: 4];
    endfunction

endpackage

// File: rtl/sbox_restore_fsm.sv
// sbox_restore_fsm
// Sequencer that walks every table entry once, one per cycle, so the parent
// can rewrite it with its default value without needing a reset.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   restore_req   start request (ignored while a restore is running)
//   busy          high for the whole restore
//   restore_done  high during the cycle that writes the last entry
//   restore_we    entry at restore_ptr is rewritten at the next edge
//   restore_ptr   entry being restored this cycle

module sbox_restore_fsm #(
    parameter int PTR_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restore_req,
    output logic             busy,
    output logic             restore_done,
    output logic             restore_we,
    output logic [PTR_W-1:0] restore_ptr
);
    import des_sbox_pkg::*;

    localparam logic [PTR_W-1:0] LAST_PTR = '1;

    restore_state_t   state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    // State and pointer registers; a reset aborts any restore in progress
    // and leaves the sequencer idle at entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic. While restoring, every cycle writes one entry; the
    // cycle that writes the last entry also flags completion and heads back
    // to idle, so a full pass takes exactly one cycle per entry.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        busy         = 1'b0;
        restore_done = 1'b0;
        restore_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (restore_req) begin
                    state_d = ST_RESTORE;
                    ptr_d   = '0;
                end
            end
            ST_RESTORE: begin
                busy       = 1'b1;
                restore_we = 1'b1;
                if (ptr_q == LAST_PTR) begin
                    restore_done = 1'b1;
                    state_d      = ST_IDLE;
                    ptr_d        = '0;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign restore_ptr = ptr_q;

endmodule

// File: rtl/sbox_prog_table.sv
// sbox_prog_table
// Run-time programmable DES S-box. Holds 4 rows x 2^(IN_W-2) columns of
// OUT_W-bit entries, reset to DES table SBOX_ID+1 for the 6-in/4-out
// geometry (all zero otherwise).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_valid/i_ready/i_data          lookup request (row = outer bits)
//   o_valid/o_data                  lookup result (registered if LOOKUP_REG)
//   wr_valid/wr_ready/wr_sel/wr_row/wr_col/wr_data
//                                   shared programming bus write port
//   rd_req/rd_sel/rd_row/rd_col     read-back request
//   rd_valid/rd_data                read-back result, one cycle later
//   restore_req/busy/restore_done   restore-defaults sequencer control

module sbox_prog_table #(
    parameter int SBOX_ID    = 0,
    parameter int IN_W       = 6,
    parameter int OUT_W      = 4,
    parameter int LOOKUP_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [IN_W-1:0]   i_data,
    output logic              o_valid,
    output logic [OUT_W-1:0]  o_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [2:0]        wr_sel,
    input  logic [1:0]        wr_row,
    input  logic [IN_W-3:0]   wr_col,
    input  logic [OUT_W-1:0]  wr_data,
    input  logic              rd_req,
    input  logic [2:0]        rd_sel,
    input  logic [1:0]        rd_row,
    input  logic [IN_W-3:0]   rd_col,
    output logic              rd_valid,
    output logic [OUT_W-1:0]  rd_data,
    input  logic              restore_req,
    output logic              busy,
    output logic              restore_done
);
    import des_sbox_pkg::*;

    localparam int              DEPTH    = 1 << IN_W;
    localparam bit              DES_GEOM = (IN_W == DES_IN_W) && (OUT_W == DES_OUT_W);
    localparam logic [ID_W-1:0] MY_ID    = ID_W'(SBOX_ID);

    // Default value of a table entry addressed as {row, col}.
    function automatic logic [OUT_W-1:0] default_entry(input int unsigned idx);
        logic [OUT_W-1:0] v;
        v = '0;
        if (DES_GEOM) begin
            v = OUT_W'(sbox_default(MY_ID, 2'(idx >> 4), 4'(idx)));
        end
        return v;
    endfunction

    logic [OUT_W-1:0] mem [DEPTH];
    logic             restore_we;
    logic [IN_W-1:0]  restore_ptr;
    logic [IN_W-1:0]  lk_addr;
    logic [IN_W-1:0]  wr_addr;
    logic [IN_W-1:0]  rd_addr;
    logic             lookup_fire;
    logic             wr_fire;
    logic             rd_hit;

    sbox_restore_fsm #(
        .PTR_W (IN_W)
    ) u_restore_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .restore_req  (restore_req),
        .busy         (busy),
        .restore_done (restore_done),
        .restore_we   (restore_we),
        .restore_ptr  (restore_ptr)
    );

    // The outer input bits pick the row, the inner bits the column; storage
    // is addressed {row, col} so the restore pointer walks rows in order.
    assign lk_addr = {i_data[IN_W-1], i_data[0], i_data[IN_W-2:1]};
    assign wr_addr = {wr_row, wr_col};
    assign rd_addr = {rd_row, rd_col};

    // Writes to other S-boxes on the shared bus are simply ignored; ready
    // is only withheld while restoring so the bus never stalls otherwise.
    assign i_ready     = ~busy;
    assign wr_ready    = ~busy;
    assign lookup_fire = i_valid && i_ready;
    assign wr_fire     = wr_valid && wr_ready && (wr_sel == MY_ID);
    assign rd_hit      = rd_req && (rd_sel == MY_ID);

    // Table storage. Reset reloads the defaults at once (also aborting a
    // restore); the sequencer rewrites one entry per cycle; bus writes land
    // at the edge, so same-cycle lookups and read-backs see the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= default_entry(i);
            end
        end else if (restore_we) begin
            mem[restore_ptr] <= default_entry(32'(restore_ptr));
        end else if (wr_fire) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-back port: valid for one cycle per matching request, data holds
    // between requests. Works during a restore and shows current contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_hit;
            if (rd_hit) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

    generate
        if (LOOKUP_REG != 0) begin : g_lookup_reg
            // Registered lookup: one cycle latency, data holds when idle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_valid <= 1'b0;
                    o_data  <= '0;
                end else begin
                    o_valid <= lookup_fire;
                    if (lookup_fire) begin
                        o_data <= mem[lk_addr];
                    end
                end
            end
        end else begin : g_lookup_comb
            assign o_valid = lookup_fire;
            assign o_data  = mem[lk_addr];
        end
    endgenerate

endmodule

// File: tb/tb_sbox_prog_table.sv
// tb_sbox_prog_table
// Self-checking bench for sbox_prog_table (SBOX_ID=6, i.e. DES S7): one
// registered-lookup instance and one combinational-lookup instance on the
// same buses, a scoreboard for the registered lookup path, table-driven
// lookup vectors and hand-written write/restore/reset sequences.

module tb_sbox_prog_table;

    typedef struct {
        logic [5:0] data;
        logic [3:0] exp;
        string      name;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       i_valid;
    logic [5:0] i_data;
    logic       wr_valid;
    logic [2:0] wr_sel;
    logic [1:0] wr_row;
    logic [3:0] wr_col;
    logic [3:0] wr_data;
    logic       rd_req;
    logic [2:0] rd_sel;
    logic [1:0] rd_row;
    logic [3:0] rd_col;
    logic       restore_req;

    logic       i_ready, o_valid, wr_ready, rd_valid, busy, restore_done;
    logic [3:0] o_data, rd_data;
    logic       c_i_ready, c_o_valid, c_wr_ready, c_rd_valid, c_busy, c_restore_done;
    logic [3:0] c_o_data, c_rd_data;

    int         n_checks;
    int         n_fail;
    int         done_seen;
    int         s7 [64];
    logic [3:0] model [64];
    logic [3:0] sbq [$];
    vec_t       vecs [6];

    sbox_prog_table #(
        .SBOX_ID (6), .IN_W (6), .OUT_W (4), .LOOKUP_REG (1)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .i_valid (i_valid), .i_ready (i_ready), .i_data (i_data),
        .o_valid (o_valid), .o_data (o_data),
        .wr_valid (wr_valid), .wr_ready (wr_ready), .wr_sel (wr_sel),
        .wr_row (wr_row), .wr_col (wr_col), .wr_data (wr_data),
        .rd_req (rd_req), .rd_sel (rd_sel), .rd_row (rd_row), .rd_col (rd_col),
        .rd_valid (rd_valid), .rd_data (rd_data),
        .restore_req (restore_req), .busy (busy), .restore_done (restore_done)
    );

    sbox_prog_table #(
        .SBOX_ID (6), .IN_W (6), .OUT_W (4), .LOOKUP_REG (0)
    ) dut_comb (
        .clk (clk), .rst_n (rst_n),
        .i_valid (i_valid), .i_ready (c_i_ready), .i_data (i_data),
        .o_valid (c_o_valid), .o_data (c_o_data),
        .wr_valid (wr_valid), .wr_ready (c_wr_ready), .wr_sel (wr_sel),
        .wr_row (wr_row), .wr_col (wr_col), .wr_data (wr_data),
        .rd_req (rd_req), .rd_sel (rd_sel), .rd_row (rd_row), .rd_col (rd_col),
        .rd_valid (c_rd_valid), .rd_data (c_rd_data),
        .restore_req (restore_req), .busy (c_busy), .restore_done (c_restore_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a stuck design can never hang the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int tb_idx(input logic [5:0] d);
        return int'({d[5], d[0]}) * 16 + int'(d[4:1]);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one lookup for a cycle; the combinational instance is checked in
    // the same cycle, the registered result is left for the caller.
    task automatic applyStimulus(input logic [5:0] d, input logic [3:0] exp, input string name);
        i_valid = 1'b1;
        i_data  = d;
        #1;
        checkOutput({name, "_comb"}, 32'(c_o_data), 32'(exp));
        checkOutput({name, "_comb_valid"}, 32'(c_o_valid), 1);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] sel, input logic [1:0] row,
                            input logic [3:0] col, input logic [3:0] data);
        wr_valid = 1'b1;
        wr_sel   = sel;
        wr_row   = row;
        wr_col   = col;
        wr_data  = data;
        #1;
        checkOutput("wr_ready", 32'(wr_ready), 1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] sel, input logic [1:0] row, input logic [3:0] col,
                           input logic exp_valid, input logic [3:0] exp_data, input string name);
        rd_req = 1'b1;
        rd_sel = sel;
        rd_row = row;
        rd_col = col;
        @(posedge clk); #1;
        rd_req = 1'b0;
        checkOutput({name, "_rd_valid"}, 32'(rd_valid), 32'(exp_valid));
        checkOutput({name, "_rd_data"}, 32'(rd_data), 32'(exp_data));
        checkOutput({name, "_rd_data_comb_inst"}, 32'(c_rd_data), 32'(exp_data));
    endtask

    // Scoreboard step, once per cycle on the falling edge: compare any
    // registered result against the oldest expectation, then record the
    // lookup accepted this cycle and apply this cycle's write to the model.
    task automatic scoreboard_step();
        if (!rst_n) begin
            sbq.delete();
            for (int i = 0; i < 64; i++) model[i] = 4'(s7[i]);
        end else begin
            if (o_valid) begin
                if (sbq.size() == 0) begin
                    checkOutput("sb_unexpected_valid", 32'(o_valid), 0);
                end else begin
                    checkOutput("sb_lookup", 32'(o_data), 32'(sbq.pop_front()));
                end
            end else if (sbq.size() != 0) begin
                checkOutput("sb_missing_valid", 32'(o_valid), 1);
                sbq.delete();
            end
            if (i_valid && i_ready) sbq.push_back(model[tb_idx(i_data)]);
            if (wr_valid && wr_ready && wr_sel == 3'd6) model[int'({wr_row, wr_col})] = wr_data;
            if (restore_done) begin
                done_seen++;
                for (int i = 0; i < 64; i++) model[i] = 4'(s7[i]);
            end
        end
    endtask

    initial begin
        int cyc;
        int done_cnt;
        int done_cyc;
        int done_before;

        s7 = '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
               13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
                1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
                6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12};

        vecs[0] = '{6'b000000, 4'd4,  "lk_r0c0"};
        vecs[1] = '{6'b100001, 4'd6,  "lk_r3c0"};
        vecs[2] = '{6'b000101, 4'd11, "lk_r1c2"};
        vecs[3] = '{6'b111111, 4'd12, "lk_r3c15"};
        vecs[4] = '{6'b011110, 4'd1,  "lk_r0c15"};
        vecs[5] = '{6'b100000, 4'd1,  "lk_r2c0"};

        n_checks = 0;
        n_fail = 0;
        done_seen = 0;
        rst_n = 1'b0;
        i_valid = 1'b0; i_data = '0;
        wr_valid = 1'b0; wr_sel = '0; wr_row = '0; wr_col = '0; wr_data = '0;
        rd_req = 1'b0; rd_sel = '0; rd_row = '0; rd_col = '0;
        restore_req = 1'b0;

        fork
            forever begin
                @(negedge clk);
                scoreboard_step();
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset values");
        checkOutput("rst_o_valid", 32'(o_valid), 0);
        checkOutput("rst_o_data", 32'(o_data), 0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 0);
        checkOutput("rst_rd_data", 32'(rd_data), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_restore_done", 32'(restore_done), 0);
        checkOutput("rst_i_ready", 32'(i_ready), 1);
        checkOutput("rst_wr_ready", 32'(wr_ready), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] default lookups");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(vecs[k].data, vecs[k].exp, vecs[k].name);
            checkOutput({vecs[k].name, "_valid"}, 32'(o_valid), 1);
            checkOutput(vecs[k].name, 32'(o_data), 32'(vecs[k].exp));
        end
        @(posedge clk); #1;
        checkOutput("idle_o_valid", 32'(o_valid), 0);
        checkOutput("idle_o_data_hold", 32'(o_data), 1);

        $display("[TB] writes");
        do_write(3'd3, 2'd1, 4'd2, 4'hF);
        applyStimulus(6'b000101, 4'd11, "wr_other_sel");
        checkOutput("wr_other_sel", 32'(o_data), 11);
        do_write(3'd6, 2'd1, 4'd2, 4'hF);
        applyStimulus(6'b000101, 4'hF, "wr_own_sel");
        checkOutput("wr_own_sel", 32'(o_data), 'hF);

        $display("[TB] write/lookup collision");
        wr_valid = 1'b1; wr_sel = 3'd6; wr_row = 2'd0; wr_col = 4'd0; wr_data = 4'h9;
        applyStimulus(6'b000000, 4'd4, "coll_old");
        wr_valid = 1'b0;
        checkOutput("coll_old", 32'(o_data), 4);
        applyStimulus(6'b000000, 4'h9, "coll_new");
        checkOutput("coll_new", 32'(o_data), 9);

        do_read(3'd6, 2'd1, 4'd2, 1'b1, 4'hF, "rb_edited");
        do_read(3'd5, 2'd0, 4'd0, 1'b0, 4'hF, "rb_other_sel");

        do_write(3'd6, 2'd3, 4'd15, 4'h0);
        do_write(3'd6, 2'd2, 4'd7, 4'h5);
        do_write(3'd6, 2'd1, 4'd0, 4'hA);

        $display("[TB] restore");
        restore_req = 1'b1;
        @(posedge clk); #1;
        restore_req = 1'b0;
        cyc = 0;
        done_cnt = 0;
        done_cyc = -1;
        while (busy && cyc < 200) begin
            checkOutput("restore_i_ready", 32'(i_ready), 0);
            checkOutput("restore_wr_ready", 32'(wr_ready), 0);
            checkOutput("restore_busy_comb_inst", 32'(c_busy), 1);
            if (restore_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cyc == 6) begin
                checkOutput("restore_rb_valid", 32'(rd_valid), 1);
                checkOutput("restore_rb_data", 32'(rd_data), 4);
            end
            rd_req = (cyc == 5);
            rd_sel = 3'd6; rd_row = 2'd0; rd_col = 4'd0;
            restore_req = (cyc == 10);
            i_valid = (cyc == 12);
            i_data = '0;
            @(posedge clk); #1;
            cyc++;
        end
        rd_req = 1'b0; restore_req = 1'b0; i_valid = 1'b0;
        checkOutput("restore_busy_cycles", 32'(cyc), 64);
        checkOutput("restore_done_count", 32'(done_cnt), 1);
        checkOutput("restore_done_cycle", 32'(done_cyc), 63);
        checkOutput("restore_done_after", 32'(restore_done), 0);
        do_read(3'd6, 2'd1, 4'd2, 1'b1, 4'd11, "rb_restored");
        applyStimulus(6'b111111, 4'd12, "restored_r3c15");
        checkOutput("restored_r3c15", 32'(o_data), 12);
        applyStimulus(6'b101110, 4'd14, "restored_r2c7");
        checkOutput("restored_r2c7", 32'(o_data), 14);
        applyStimulus(6'b000001, 4'd13, "restored_r1c0");
        checkOutput("restored_r1c0", 32'(o_data), 13);

        $display("[TB] reset during restore");
        do_write(3'd6, 2'd3, 4'd15, 4'h0);
        do_write(3'd6, 2'd2, 4'd7, 4'h5);
        restore_req = 1'b1;
        @(posedge clk); #1;
        restore_req = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("mid_restore_busy", 32'(busy), 1);
        done_before = done_seen;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_restore_done", 32'(restore_done), 0);
        checkOutput("abort_i_ready", 32'(i_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        checkOutput("abort_no_done_pulse", 32'(done_seen), 32'(done_before));
        checkOutput("abort_idle", 32'(busy), 0);
        do_read(3'd6, 2'd3, 4'd15, 1'b1, 4'd12, "abort_rb_r3c15");
        do_read(3'd6, 2'd2, 4'd7, 1'b1, 4'd14, "abort_rb_r2c7");

        $display("[TB] full sweep");
        for (int d = 0; d < 64; d++) begin
            i_valid = 1'b1;
            i_data = 6'(d);
            #1;
            checkOutput("sweep_comb", 32'(c_o_data), 32'(s7[tb_idx(6'(d))]));
            checkOutput("sweep_comb_valid", 32'(c_o_valid), 1);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("sb_drained", 32'(sbq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
